// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan path: digit-select codes,
// the anode rotation order and default timing parameters.
package display_pkg;

  localparam logic [3:0] DIG_OP   = 4'b0001;
  localparam logic [3:0] DIG_ZERO = 4'b0010;
  localparam logic [3:0] DIG_LO   = 4'b0100;
  localparam logic [3:0] DIG_HI   = 4'b1000;

  localparam int DIV_DEFAULT   = 100000;
  localparam int GUARD_DEFAULT = 64;

  localparam logic [3:0] ANODE_SEQ [4] = '{DIG_OP, DIG_ZERO, DIG_LO, DIG_HI};

  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    return ANODE_SEQ[idx];
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Bundle between the ALU-side producer and the scan controller; the
// controller is the slave, the ALU/board side is the master.
interface display_scan_if;
  logic [15:0] Y_in;
  logic [3:0]  OP_in;
  logic        load;
  logic        blank;
  logic [15:0] Y;
  logic [3:0]  OP;
  logic [3:0]  anode;
  logic [3:0]  an_n;
  logic        pending;
  logic        frame_done;

  modport master (
    output Y_in, OP_in, load, blank,
    input  Y, OP, anode, an_n, pending, frame_done
  );

  modport slave (
    input  Y_in, OP_in, load, blank,
    output Y, OP, anode, an_n, pending, frame_done
  );
endinterface

// File: rtl/scan_prescaler.sv
// Slot-length divider: div_cnt runs 0..DIV-1, tick marks the terminal cycle.
module scan_prescaler #(
  parameter int DIV   = 100000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] div_cnt,
  output logic             tick
);

  logic [CNT_W-1:0] div_cnt_reg;

  assign tick    = (div_cnt_reg == CNT_W'(DIV - 1));
  assign div_cnt = div_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit-scan controller: rotates the one-hot digit select, applies the
// anode guard/blank, and swaps in new results only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int GUARD = GUARD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  scan_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_cnt (div_cnt),
    .tick    (tick)
  );

  logic [1:0]   index_reg, index_next;
  logic [3:0]   anode_reg, anode_next;
  logic [3:0]   an_n_reg, an_n_next;
  logic [15:0]  y_reg, y_next, pend_y_reg, pend_y_next;
  logic [3:0]   op_reg, op_next, pend_op_reg, pend_op_next;
  logic         pending_reg, pending_next;
  logic         frame_done_reg, frame_done_next;
  logic [CNT_W:0] cnt_inc;
  logic         guard_next, frame_bound;

  always_comb begin
    cnt_inc         = {1'b0, div_cnt} + (CNT_W + 1)'(1);
    frame_bound     = tick && (index_reg == 2'd3);
    index_next      = tick ? index_reg + 2'd1 : index_reg;
    anode_next      = anode_of(index_next);
    // Every slot restarts at div_cnt 0, which is always inside the guard.
    guard_next      = tick || (cnt_inc < (CNT_W + 1)'(GUARD));
    // Registered pulse: arm one cycle early so it lands on the terminal cycle.
    frame_done_next = (div_cnt == CNT_W'(DIV - 2)) && (index_reg == 2'd3);

    y_next       = y_reg;
    op_next      = op_reg;
    pend_y_next  = pend_y_reg;
    pend_op_next = pend_op_reg;
    pending_next = pending_reg;

    if (bus.load) begin
      pend_y_next  = bus.Y_in;
      pend_op_next = bus.OP_in;
      pending_next = 1'b1;
    end
    if (frame_bound) begin
      pending_next = 1'b0;
      if (bus.load) begin
        y_next  = bus.Y_in;
        op_next = bus.OP_in;
      end else if (pending_reg) begin
        y_next  = pend_y_reg;
        op_next = pend_op_reg;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an_n
    assign an_n_next[gi] = bus.blank | guard_next | ~anode_next[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg      <= 2'd0;
      anode_reg      <= DIG_OP;
      an_n_reg       <= 4'b1111;
      y_reg          <= '0;
      op_reg         <= '0;
      pend_y_reg     <= '0;
      pend_op_reg    <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      index_reg      <= index_next;
      anode_reg      <= anode_next;
      an_n_reg       <= an_n_next;
      y_reg          <= y_next;
      op_reg         <= op_next;
      pend_y_reg     <= pend_y_next;
      pend_op_reg    <= pend_op_next;
      pending_reg    <= pending_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.Y          = y_reg;
  assign bus.OP         = op_reg;
  assign bus.anode      = anode_reg;
  assign bus.an_n       = an_n_reg;
  assign bus.pending    = pending_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at DIV=8, GUARD=2 with a queue of
// expected display values popped at each frame boundary.
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_if bus ();

  display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] y;
    logic [3:0]  op;
  } disp_t;

  disp_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic        blank_last = 1'b0;
  logic        pend_exp = 1'b0;
  logic        load_in_frame = 1'b0;
  logic [15:0] shown_y = '0;
  logic [3:0]  shown_op = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [3:0] a_exp;
    logic [3:0] an_exp;
    int pos;
    a_exp  = 4'b0001 << ((k / DIV) % 4);
    pos    = k % DIV;
    an_exp = (pos < GUARD || blank_last) ? 4'hF : ~a_exp;
    chk("anode", 32'(bus.anode), 32'(a_exp));
    chk("an_n", 32'(bus.an_n), 32'(an_exp));
    chk("frame_done", 32'(bus.frame_done), 32'((k % FRAME) == FRAME - 1));
    chk("pending", 32'(bus.pending), 32'(pend_exp));
    chk("Y", 32'(bus.Y), 32'(shown_y));
    chk("OP", 32'(bus.OP), 32'(shown_op));
    $display("k=%0d anode=%b an_n=%b fd=%b pend=%b Y=%h OP=%h",
             k, bus.anode, bus.an_n, bus.frame_done, bus.pending, bus.Y, bus.OP);
  endtask

  task automatic step();
    logic  bnd;
    logic  ld;
    logic  bl;
    disp_t e;
    bnd = ((k % FRAME) == FRAME - 1);
    ld  = bus.load;
    bl  = bus.blank;
    @(posedge clk);
    k++;
    blank_last = bl;
    if (ld && !bnd) pend_exp = 1'b1;
    if (bnd) begin
      pend_exp      = 1'b0;
      load_in_frame = 1'b0;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        shown_y  = e.y;
        shown_op = e.op;
      end
    end
    @(negedge clk);
    bus.load = 1'b0;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_load(input logic [15:0] y, input logic [3:0] op);
    disp_t e;
    bus.Y_in  = y;
    bus.OP_in = op;
    bus.load  = 1'b1;
    if (load_in_frame) void'(exp_q.pop_back());
    e.y  = y;
    e.op = op;
    exp_q.push_back(e);
    load_in_frame = 1'b1;
  endtask

  initial begin
    bus.Y_in  = '0;
    bus.OP_in = '0;
    bus.load  = 1'b0;
    bus.blank = 1'b0;

    repeat (3) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    k = 0;
    check_cycle();

    // Deferred load mid-frame, applied at the first boundary.
    run(10);
    drive_load(16'hBEEF, 4'h3);
    run(22);

    // Two loads in one frame: the later one is displayed.
    run(4);
    drive_load(16'h1234, 4'h1);
    run(14);
    drive_load(16'h5678, 4'h2);
    run(45);

    // Bypass load exactly on the boundary cycle (k=95).
    drive_load(16'hABCD, 4'hC);
    run(1);

    // Blank for 10 cycles spanning the slot change at k=104.
    run(4);
    bus.blank = 1'b1;
    run(10);
    bus.blank = 1'b0;
    run(20);

    // Leave a load pending, then reset mid-slot at index 2.
    drive_load(16'h7777, 4'h7);
    run(18);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_anode", 32'(bus.anode), 32'(4'b0001));
    chk("rst_an_n", 32'(bus.an_n), 32'(4'b1111));
    chk("rst_Y", 32'(bus.Y), 32'(16'h0000));
    chk("rst_OP", 32'(bus.OP), 32'(4'h0));
    chk("rst_pending", 32'(bus.pending), 32'(1'b0));
    chk("rst_frame_done", 32'(bus.frame_done), 32'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    exp_q.delete();
    shown_y = '0;
    shown_op = '0;
    pend_exp = 1'b0;
    load_in_frame = 1'b0;
    blank_last = 1'b0;
    check_cycle();
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
